// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX write-port arbiter and its requesters.
package uart_tx_arbiter_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] UartFifoData_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } UartArbState_t;

    localparam UartFifoData_t ESC = 8'h1B;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the FIFO write port of the TX arbiter.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = UART_DATA_W
) ();

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               fifo_full;
    logic                               fifo_write_request;
    logic [DATA_WIDTH-1:0]              fifo_in_data;
    logic [ID_W-1:0]                    grant_id;
    logic                               busy;
    logic                               abort;

    modport master (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_full,
        output req_ready,
        output fifo_write_request,
        output fifo_in_data,
        output grant_id,
        output busy,
        output abort
    );

    modport slave (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_full,
        input  req_ready,
        input  fifo_write_request,
        input  fifo_in_data,
        input  grant_id,
        input  busy,
        input  abort
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request after last_grant, wrapping.
module uart_tx_arbiter_rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-message round-robin arbiter for the UART TX FIFO write port,
// with a watchdog that releases a requester stalled mid-message.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.master bus
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    UartArbState_t state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W-1:0]       winner;
    logic                  any_valid;
    logic                  g_valid;
    logic                  g_last;
    logic [NUM_REQ-1:0]    ready;
    logic                  wr;
    logic [DATA_WIDTH-1:0] data;
    logic                  ab;

    uart_tx_arbiter_rr_picker #(
        .NUM_REQ   (NUM_REQ)
    ) u_picker (
        .req       (bus.req_valid),
        .last_grant(last_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign g_valid = bus.req_valid[grant_q];
    assign g_last  = bus.req_last[grant_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ready   = '0;
        wr      = 1'b0;
        data    = '0;
        ab      = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (any_valid) begin
                    grant_d = winner;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A present byte keeps the grant alive even while the FIFO is full.
                if (g_valid) begin
                    cnt_d = '0;
                    if (!bus.fifo_full) begin
                        ready[grant_q] = 1'b1;
                        wr             = 1'b1;
                        data           = bus.req_data[grant_q];
                        if (g_last) begin
                            state_d = ARB_IDLE;
                            last_d  = grant_q;
                        end
                    end
                end else if (cnt_q == CNT_MAX) begin
                    ab      = 1'b1;
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.req_ready          = ready;
    assign bus.fifo_write_request = wr;
    assign bus.fifo_in_data       = data;
    assign bus.grant_id           = grant_q;
    assign bus.busy               = (state_q == ARB_BUSY);
    assign bus.abort              = ab;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: scripted scenarios plus random message traffic
// compared against a message-level round-robin model.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int TMO = 8;

    typedef struct packed {
        logic       w;
        logic [7:0] d;
        logic       busy;
        logic       gid;
        logic       ab;
        logic [1:0] rdy;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (2),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] qd0[$];
    logic [7:0] qd1[$];
    bit         ql0[$];
    bit         ql1[$];
    bit         en0, en1;
    bit         full_now;
    int         full_mode;
    int         full_pct;
    int         full_lo, full_hi;

    obs_t       log_q[$];
    int         wr_src[$];
    logic [7:0] wr_data[$];
    int         exp_src[$];
    logic [7:0] exp_data[$];
    int         aborts;
    int         viol;
    int         cyc;

    task automatic drive_inputs();
        bus.fifo_full    = full_now;
        bus.req_valid[0] = en0 && (qd0.size() != 0);
        bus.req_data[0]  = (qd0.size() != 0) ? qd0[0] : 8'h00;
        bus.req_last[0]  = (ql0.size() != 0) ? ql0[0] : 1'b0;
        bus.req_valid[1] = en1 && (qd1.size() != 0);
        bus.req_data[1]  = (qd1.size() != 0) ? qd1[0] : 8'h00;
        bus.req_last[1]  = (ql1.size() != 0) ? ql1[0] : 1'b0;
    endtask

    task automatic clear_log();
        log_q.delete();
        wr_src.delete();
        wr_data.delete();
        aborts = 0;
        viol   = 0;
        cyc    = 0;
    endtask

    // One clock: drive at negedge, observe 1ns later, retire accepted bytes.
    task automatic cycle();
        obs_t       o;
        logic [7:0] exp_d;
        @(negedge clk);
        case (full_mode)
            1:       full_now = (int'($urandom_range(99)) < full_pct);
            2:       full_now = (cyc >= full_lo) && (cyc < full_hi);
            default: full_now = 1'b0;
        endcase
        drive_inputs();
        #1;
        o.w    = bus.fifo_write_request;
        o.d    = bus.fifo_in_data;
        o.busy = bus.busy;
        o.gid  = bus.grant_id;
        o.ab   = bus.abort;
        o.rdy  = bus.req_ready;
        log_q.push_back(o);
        if (bus.abort) aborts++;
        if ($countones(bus.req_ready) > 1) viol++;
        if ((bus.req_ready & ~bus.req_valid) != 2'b00) viol++;
        if (bus.fifo_full && bus.req_ready != 2'b00) viol++;
        if (bus.fifo_write_request != (bus.req_ready != 2'b00)) viol++;
        if (bus.req_ready != 2'b00 && !bus.busy) viol++;
        if (bus.req_ready != 2'b00 && !bus.req_ready[bus.grant_id]) viol++;
        exp_d = 8'h00;
        if (bus.req_ready[0] && qd0.size() != 0) exp_d = qd0[0];
        else if (bus.req_ready[1] && qd1.size() != 0) exp_d = qd1[0];
        if (bus.fifo_in_data !== exp_d) viol++;
        if (bus.fifo_write_request) begin
            wr_data.push_back(bus.fifo_in_data);
            wr_src.push_back(bus.req_ready[1] ? 1 : 0);
        end
        if (bus.req_ready[0] && qd0.size() != 0) begin
            void'(qd0.pop_front());
            void'(ql0.pop_front());
        end
        if (bus.req_ready[1] && qd1.size() != 0) begin
            void'(qd1.pop_front());
            void'(ql1.pop_front());
        end
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        qd0.delete(); ql0.delete();
        qd1.delete(); ql1.delete();
        en0 = 1'b1;
        en1 = 1'b1;
        full_mode = 0;
        full_now  = 1'b0;
        drive_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((qd0.size() + qd1.size() > 0 || bus.busy) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: ran %0d cycles, budget %0d", n, budget);
        end
    endtask

    task automatic gen_msgs(input int r, input int nmsg, input int maxlen);
        int len;
        for (int m = 0; m < nmsg; m++) begin
            len = int'($urandom_range(maxlen, 1));
            for (int b = 0; b < len; b++) begin
                if (r == 0) begin
                    qd0.push_back(8'($urandom_range(255)));
                    ql0.push_back(b == len - 1);
                end else begin
                    qd1.push_back(8'($urandom_range(255)));
                    ql1.push_back(b == len - 1);
                end
            end
        end
    endtask

    // Whole messages, alternating requesters, skipping one that has nothing left.
    task automatic build_expected(input int last);
        logic [7:0] d0[$];
        logic [7:0] d1[$];
        bit         l0[$];
        bit         l1[$];
        int         r;
        bit         done;
        d0 = qd0; l0 = ql0;
        d1 = qd1; l1 = ql1;
        exp_src.delete();
        exp_data.delete();
        while (d0.size() + d1.size() > 0) begin
            r = 1 - last;
            if (r == 0 && d0.size() == 0) r = 1;
            if (r == 1 && d1.size() == 0) r = 0;
            done = 1'b0;
            while (!done && (r == 0 ? d0.size() : d1.size()) > 0) begin
                if (r == 0) begin
                    exp_data.push_back(d0.pop_front());
                    done = l0.pop_front();
                end else begin
                    exp_data.push_back(d1.pop_front());
                    done = l1.pop_front();
                end
                exp_src.push_back(r);
            end
            last = r;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_last  = 2'b11;
        bus.req_data  = {8'h55, 8'hAA};
        bus.fifo_full = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.abort !== 1'b0) begin
            errors++; $display("FAIL reset_abort: got %b want 0", bus.abort);
        end
        checks++;
        if (bus.fifo_write_request !== 1'b0) begin
            errors++;
            $display("FAIL reset_write: got %b want 0", bus.fifo_write_request);
        end
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", bus.req_ready);
        end
        checks++;
        if (bus.grant_id !== 1'b0) begin
            errors++; $display("FAIL reset_grant: got %b want 0", bus.grant_id);
        end
        checks++;
        if (bus.fifo_in_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", bus.fifo_in_data);
        end
    endtask

    task automatic test_single_byte();
        apply_reset();
        qd0.push_back(8'h61); ql0.push_back(1'b1);
        repeat (4) cycle();
        checks++;
        if (log_q[0].w !== 1'b0 || log_q[0].busy !== 1'b0) begin
            errors++;
            $display("FAIL single_arb: w=%b busy=%b want 0 0", log_q[0].w, log_q[0].busy);
        end
        checks++;
        if (log_q[1].w !== 1'b1 || log_q[1].d !== 8'h61) begin
            errors++;
            $display("FAIL single_write: w=%b d=%h want 1 61", log_q[1].w, log_q[1].d);
        end
        checks++;
        if (log_q[1].busy !== 1'b1 || log_q[1].gid !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: busy=%b gid=%b want 1 0",
                     log_q[1].busy, log_q[1].gid);
        end
        checks++;
        if (log_q[2].busy !== 1'b0 || log_q[2].w !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b w=%b want 0 0", log_q[2].busy, log_q[2].w);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL single_protocol: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e_d[7];
        int         e_c[7];
        int         e_s[7];
        int         wc[$];
        int         bad;
        e_d = '{ESC, 8'h5B, 8'h41, ESC, 8'h5B, 8'h30, 8'h6E};
        e_c = '{1, 2, 3, 5, 6, 7, 8};
        e_s = '{0, 0, 0, 1, 1, 1, 1};
        apply_reset();
        qd0 = '{ESC, 8'h5B, 8'h41};
        ql0 = '{1'b0, 1'b0, 1'b1};
        qd1 = '{ESC, 8'h5B, 8'h30, 8'h6E};
        ql1 = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_drain(40);
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].w) wc.push_back(i);
        checks++;
        if (wc.size() != 7) begin
            errors++; $display("FAIL b2b_count: got %0d writes want 7", wc.size());
        end
        bad = 0;
        for (int i = 0; i < 7 && i < wc.size(); i++) begin
            if (wc[i] != e_c[i] || wr_data[i] !== e_d[i] || wr_src[i] != e_s[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL b2b_stream: got %0d bad bytes want 0", bad);
        end
        checks++;
        if (log_q[4].busy !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: busy=%b want 0", log_q[4].busy);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL b2b_protocol: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_fifo_stall();
        logic [7:0] msg[$];
        int         bad;
        int         inwin;
        apply_reset();
        gen_msgs(1, 1, 1);
        qd1.delete(); ql1.delete();
        for (int i = 0; i < 6; i++) begin
            qd1.push_back(8'($urandom_range(255)));
            ql1.push_back(i == 5);
        end
        msg = qd1;
        full_mode = 2;
        full_lo = 3;
        full_hi = 13;
        run_drain(60);
        checks++;
        if (wr_data.size() != 6) begin
            errors++; $display("FAIL stall_count: got %0d want 6", wr_data.size());
        end
        bad = 0;
        for (int i = 0; i < 6 && i < wr_data.size(); i++)
            if (wr_data[i] !== msg[i] || wr_src[i] != 1) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_stream: got %0d bad bytes want 0", bad);
        end
        inwin = 0;
        for (int i = 3; i < 13 && i < log_q.size(); i++)
            if (log_q[i].w || log_q[i].rdy != 2'b00) inwin++;
        checks++;
        if (inwin != 0) begin
            errors++; $display("FAIL stall_window: got %0d writes want 0", inwin);
        end
        checks++;
        if (aborts != 0) begin
            errors++; $display("FAIL stall_abort: got %0d aborts want 0", aborts);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL stall_protocol: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_fairness();
        int bad;
        int n0;
        int n1;
        apply_reset();
        gen_msgs(0, 50, 1);
        gen_msgs(1, 50, 1);
        build_expected(1);
        full_mode = 1;
        full_pct  = 20;
        run_drain(2000);
        bad = 0;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < wr_src.size(); k++) begin
            if (wr_src[k] != k % 2) bad++;
            if (wr_src[k] == 0) n0++; else n1++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL fair_alternate: got %0d out of order want 0", bad);
        end
        checks++;
        if (n0 != 50 || n1 != 50) begin
            errors++; $display("FAIL fair_count: got %0d/%0d want 50/50", n0, n1);
        end
        bad = 0;
        for (int k = 0; k < exp_data.size() && k < wr_data.size(); k++)
            if (wr_data[k] !== exp_data[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL fair_data: got %0d bad bytes want 0", bad);
        end
        checks++;
        if (aborts != 0 || viol != 0) begin
            errors++;
            $display("FAIL fair_protocol: aborts=%0d viol=%0d want 0 0", aborts, viol);
        end
    endtask

    task automatic test_random_msgs();
        int bad;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            gen_msgs(0, int'($urandom_range(5, 1)), 5);
            gen_msgs(1, int'($urandom_range(5, 1)), 6);
            build_expected(1);
            full_mode = 1;
            full_pct  = 30;
            run_drain(2000);
            checks++;
            if (wr_data.size() != exp_data.size()) begin
                errors++;
                $display("FAIL rand_count it%0d: got %0d want %0d",
                         it, wr_data.size(), exp_data.size());
            end
            bad = 0;
            for (int k = 0; k < exp_data.size() && k < wr_data.size(); k++)
                if (wr_data[k] !== exp_data[k] || wr_src[k] != exp_src[k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_stream it%0d: got %0d bad bytes want 0", it, bad);
            end
            checks++;
            if (aborts != 0 || viol != 0) begin
                errors++;
                $display("FAIL rand_protocol it%0d: aborts=%0d viol=%0d want 0 0",
                         it, aborts, viol);
            end
        end
    endtask

    task automatic test_timeout();
        int ab_at;
        apply_reset();
        en0 = 1'b0;
        qd0.push_back(8'h41); ql0.push_back(1'b1);
        qd1.push_back(ESC);   ql1.push_back(1'b0);
        for (int k = 0; k < 14; k++) begin
            if (k == 3) en0 = 1'b1;
            cycle();
        end
        checks++;
        if (log_q[1].w !== 1'b1 || log_q[1].d !== ESC || log_q[1].rdy !== 2'b10) begin
            errors++;
            $display("FAIL tmo_first: w=%b d=%h rdy=%b want 1 1b 10",
                     log_q[1].w, log_q[1].d, log_q[1].rdy);
        end
        ab_at = -1;
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].ab && ab_at < 0) ab_at = i;
        checks++;
        if (ab_at != 1 + TMO) begin
            errors++; $display("FAIL tmo_when: got cycle %0d want %0d", ab_at, 1 + TMO);
        end
        checks++;
        if (aborts != 1) begin
            errors++; $display("FAIL tmo_pulse: got %0d abort cycles want 1", aborts);
        end
        checks++;
        if (log_q[10].busy !== 1'b0) begin
            errors++; $display("FAIL tmo_release: busy=%b want 0", log_q[10].busy);
        end
        checks++;
        if (log_q[11].busy !== 1'b1 || log_q[11].gid !== 1'b0 ||
            log_q[11].w !== 1'b1 || log_q[11].d !== 8'h41) begin
            errors++;
            $display("FAIL tmo_regrant: busy=%b gid=%b w=%b d=%h want 1 0 1 41",
                     log_q[11].busy, log_q[11].gid, log_q[11].w, log_q[11].d);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL tmo_protocol: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            qd1.push_back(8'($urandom_range(255)));
            ql1.push_back(i == 4);
        end
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== 1'b0 || bus.abort !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: busy=%b gid=%b abort=%b want 0 0 0",
                     bus.busy, bus.grant_id, bus.abort);
        end
        checks++;
        if (bus.req_ready !== 2'b00 || bus.fifo_write_request !== 1'b0 ||
            bus.fifo_in_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_port: rdy=%b w=%b d=%h want 00 0 00",
                     bus.req_ready, bus.fifo_write_request, bus.fifo_in_data);
        end
        qd0.push_back(8'h77); ql0.push_back(1'b1);
        @(negedge clk);
        drive_inputs();
        rst = 1'b0;
        clear_log();
        cycle();
        checks++;
        if (log_q[0].busy !== 1'b1 || log_q[0].gid !== 1'b0 ||
            log_q[0].w !== 1'b1 || log_q[0].d !== 8'h77) begin
            errors++;
            $display("FAIL midrst_first: busy=%b gid=%b w=%b d=%h want 1 0 1 77",
                     log_q[0].busy, log_q[0].gid, log_q[0].w, log_q[0].d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        full_now  = 1'b0;
        full_mode = 0;
        full_pct  = 0;
        full_lo   = 0;
        full_hi   = 0;
        drive_inputs();
        clear_log();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_stall();
        test_fairness();
        test_random_msgs();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
